spi_mem_loader: RTL

Frame-level SPI slave controller that owns the instruction and data caches whenever the processor is not running. It deserialises write frames into single-cycle cache write strobes and serves dcache read-back over `miso`. It also arbitrates cache ownership between the external master and processor execution. It sits between the `uio_in` pins and the cache address/write-enable muxes, and replaces the ad-hoc buffer-plus-RECV/WRITE sequencing in the top level.

---
 rtl/tiny_proc_pkg.sv | 35 +++
 rtl/spi_frame_shifter.sv | 45 ++++
 rtl/spi_mem_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_proc_pkg.sv
// Shared definitions for the tiny processor: datapath widths, loader
// command encoding and the SPI loader state machine encoding.
package tiny_proc_pkg;

  // Cache word and address widths
  localparam int DATAPATH_W   = 8;
  localparam int CACHE_ADDR_W = 4;

  // Serial frame: 1 command bit, 4 address bits, 8 data bits
  localparam int FRAME_BITS = 13;

  // Width of the per-state bit counter
  localparam int LD_CNT_W = 4;

  // Command bit values (first bit of every frame)
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  // Loader state encoding
  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_ADDR    = 3'd1,
    LD_TURN    = 3'd2,
    LD_DATA    = 3'd3,
    LD_COMMIT  = 3'd4,
    LD_WAIT_CS = 3'd5,
    LD_RUN     = 3'd6
  } ld_state_t;

  // True for the states in which the selected chip select must stay low
  function automatic logic in_frame(input ld_state_t s);
    return (s == LD_ADDR) || (s == LD_TURN) || (s == LD_DATA);
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Shared serial shift register of the SPI loader. Shifts left (MSB first)
// with serial input at the LSB, or loads a parallel word. The serial output
// is the MSB the register will hold after this edge, so a registered miso
// driven from it is aligned with the register contents.
module spi_frame_shifter
  import tiny_proc_pkg::*;
#(
  parameter int W = DATAPATH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] q_next;

  // Next-value select: parallel load wins over shift, otherwise hold
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_data;
    end else if (shift) begin
      q_next = {q[W-2:0], sin};
    end else begin
      q_next = q;
    end
  end

  // Shift register storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign sout = q_next[W-1];

endmodule

// File: rtl/spi_mem_loader.sv
// Frame-level SPI slave that owns the icache/dcache while the processor is
// halted. Write frames become single-cycle cache write strobes, dcache read
// frames are returned over miso, and run_req hands the caches to the core.
// The serial bit clock is clk itself: one bit is sampled per cycle while the
// selected chip select is low.
module spi_mem_loader
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = DATAPATH_W,
  parameter int ADDR_W = CACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              run_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              icache_wen,
  output logic              dcache_wen,
  output logic              mem_sel,
  output logic              proc_run,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [LD_CNT_W-1:0] CNT_ZERO  = LD_CNT_W'(0);
  localparam logic [LD_CNT_W-1:0] CNT_ONE   = LD_CNT_W'(1);
  localparam logic [LD_CNT_W-1:0] ADDR_LAST = LD_CNT_W'(ADDR_W - 1);
  localparam logic [LD_CNT_W-1:0] DATA_LAST = LD_CNT_W'(DATA_W - 1);

  // Control state
  ld_state_t           state;
  ld_state_t           state_next;
  logic [LD_CNT_W-1:0] cnt;
  logic [LD_CNT_W-1:0] cnt_next;
  logic                cmd;          // latched command bit of the frame
  logic                cmd_next;
  logic                tgt_dcache;   // 1: frame targets dcache, 0: icache
  logic                tgt_dcache_next;
  logic [ADDR_W-1:0]   addr_q;

  // Datapath controls
  logic                addr_shift;
  logic                sh_load;
  logic                sh_shift;
  logic                sh_sin;
  logic                sh_sout;
  logic [DATA_W-1:0]   sh_q;
  logic                err_next;
  logic                sel_cs_low;
  logic                miso_next;

  // Chip select of the latched target; only this one can end a frame
  assign sel_cs_low = tgt_dcache ? ~csd_n : ~csi_n;

  // Read frames shift zeros in; mosi is ignored during read-back
  assign sh_sin = (cmd == CMD_WRITE) ? mosi : 1'b0;

  spi_frame_shifter #(
    .W (DATA_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (rd_data),
    .shift     (sh_shift),
    .sin       (sh_sin),
    .q         (sh_q),
    .sout      (sh_sout)
  );

  // Next-state, counter and datapath-control decode
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cmd_next        = cmd;
    tgt_dcache_next = tgt_dcache;
    addr_shift      = 1'b0;
    sh_load         = 1'b0;
    sh_shift        = 1'b0;
    err_next        = 1'b0;

    if (in_frame(state) && !sel_cs_low) begin
      // Chip select released mid-frame: drop the frame without writing
      err_next   = 1'b1;
      cnt_next   = CNT_ZERO;
      state_next = LD_IDLE;
    end else begin
      case (state)
        LD_IDLE: begin
          cnt_next = CNT_ZERO;
          if (run_req) begin
            state_next = LD_RUN;
          end else if (!csi_n && !csd_n) begin
            err_next   = 1'b1;
            state_next = LD_WAIT_CS;
          end else if (!csi_n || !csd_n) begin
            tgt_dcache_next = csi_n;
            cmd_next        = mosi;
            state_next      = LD_ADDR;
          end else begin
            state_next = LD_IDLE;
          end
        end

        LD_ADDR: begin
          addr_shift = 1'b1;
          if (cnt == ADDR_LAST) begin
            cnt_next = CNT_ZERO;
            if (cmd == CMD_WRITE) begin
              state_next = LD_DATA;
            end else if (tgt_dcache) begin
              state_next = LD_TURN;
            end else begin
              // icache has no read-back path
              err_next   = 1'b1;
              state_next = LD_WAIT_CS;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        LD_TURN: begin
          sh_load    = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = LD_DATA;
        end

        LD_DATA: begin
          sh_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            cnt_next   = CNT_ZERO;
            state_next = (cmd == CMD_WRITE) ? LD_COMMIT : LD_WAIT_CS;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        LD_COMMIT: begin
          state_next = LD_WAIT_CS;
        end

        LD_WAIT_CS: begin
          if (csi_n && csd_n) begin
            state_next = LD_IDLE;
          end else begin
            state_next = LD_WAIT_CS;
          end
        end

        LD_RUN: begin
          if (!run_req) begin
            state_next = (csi_n && csd_n) ? LD_IDLE : LD_WAIT_CS;
          end else begin
            state_next = LD_RUN;
          end
        end

        default: begin
          cnt_next   = CNT_ZERO;
          state_next = LD_IDLE;
        end
      endcase
    end
  end

  // miso carries the next read bit only while the next state is read DATA
  always_comb begin
    miso_next = 1'b0;
    if ((state_next == LD_DATA) && (cmd_next == CMD_READ)) begin
      miso_next = sh_sout;
    end else begin
      miso_next = 1'b0;
    end
  end

  // State, counter, frame attributes and address register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_IDLE;
      cnt        <= CNT_ZERO;
      cmd        <= CMD_READ;
      tgt_dcache <= 1'b0;
      addr_q     <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cmd        <= cmd_next;
      tgt_dcache <= tgt_dcache_next;
      if (addr_shift) begin
        addr_q <= {addr_q[ADDR_W-2:0], mosi};
      end
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      miso       <= 1'b0;
      icache_wen <= 1'b0;
      dcache_wen <= 1'b0;
      mem_sel    <= 1'b0;
      proc_run   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      miso       <= miso_next;
      icache_wen <= (state_next == LD_COMMIT) && !tgt_dcache_next;
      dcache_wen <= (state_next == LD_COMMIT) &&  tgt_dcache_next;
      mem_sel    <= (state_next == LD_TURN) || (state_next == LD_COMMIT);
      proc_run   <= (state_next == LD_RUN);
      busy       <= (state_next != LD_IDLE);
      frame_err  <= err_next;
    end
  end

  // Address and write data come straight from their holding registers,
  // which are stable throughout TURN and COMMIT
  assign mem_addr  = addr_q;
  assign mem_wdata = sh_q;

endmodule
